trap_unit: RTL

Machine-mode trap sequencer that consumes the trap record (valid, cause, value) raised by the pipeline and the `mret` retire event. It latches mepc/mcause/mtval, flushes the pipeline and redirects fetch to mtvec, or to mepc for `mret`. It owns the four trap CSRs and exposes a read/write port to the CSR execution unit. It sits beside the CSR unit at the commit end of the pipeline and drives the fetch stage's redirect inputs.

---
 rtl/trap_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: captures trap records, owns mtvec/mepc/mcause/mtval,
// and drives a flush followed by a fetch redirect to mtvec (trap) or mepc (mret).
//
// state       | meaning
// ST_IDLE     | waiting for trapValid / mretValid
// ST_FLUSH    | flush asserted, target already latched
// ST_REDIRECT | redirectValid asserted with redirectPc = target
module trap_unit #(
  parameter logic [31:0] MtvecReset = 32'h00001000,
  parameter int          CauseWidth = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  trapValid,
  input  logic [CauseWidth-1:0] trapCause,
  input  logic [31:0]           trapValue,
  input  logic [31:0]           trapPc,
  input  logic                  mretValid,
  input  logic                  csrWriteEnable,
  input  logic [11:0]           csrWriteAddr,
  input  logic [31:0]           csrWriteValue,
  input  logic [11:0]           csrReadAddr,
  output logic [31:0]           csrReadValue,
  output logic                  flush,
  output logic                  redirectValid,
  output logic [31:0]           redirectPc,
  output logic                  busy
);

  localparam logic [11:0] AddrMtvec  = 12'h305;
  localparam logic [11:0] AddrMepc   = 12'h341;
  localparam logic [11:0] AddrMcause = 12'h342;
  localparam logic [11:0] AddrMtval  = 12'h343;
  localparam logic [31:0] AlignMask  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_capture;
  logic        w_mret_take;
  logic        w_wr_mtvec;
  logic        w_wr_mepc;
  logic        w_wr_mcause;
  logic        w_wr_mtval;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_target;
  logic        r_flush;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_mret_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A trap always wins over a simultaneous mret.
        if (trapValid) begin
          w_capture    = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (mretValid) begin
          w_mret_take  = 1'b1;
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH:    w_state_next = ST_REDIRECT;
      ST_REDIRECT: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  assign w_wr_mtvec  = csrWriteEnable && (csrWriteAddr == AddrMtvec);
  assign w_wr_mepc   = csrWriteEnable && (csrWriteAddr == AddrMepc);
  assign w_wr_mcause = csrWriteEnable && (csrWriteAddr == AddrMcause);
  assign w_wr_mtval  = csrWriteEnable && (csrWriteAddr == AddrMtval);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state          <= ST_IDLE;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'h0;
      r_target         <= 32'h0;
    end else begin
      r_state          <= w_state_next;
      r_flush          <= (w_state_next == ST_FLUSH);
      r_redirect_valid <= (w_state_next == ST_REDIRECT);
      if (w_state_next == ST_REDIRECT) r_redirect_pc <= r_target;
      // Target is taken from the register value, before any same-cycle CSR write.
      if (w_capture)        r_target <= r_mtvec;
      else if (w_mret_take) r_target <= r_mepc;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mtvec  <= MtvecReset & AlignMask;
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
      r_mtval  <= 32'h0;
    end else begin
      if (w_wr_mtvec) r_mtvec <= csrWriteValue & AlignMask;
      if (w_capture) begin
        r_mepc   <= trapPc & AlignMask;
        r_mcause <= {{(32-CauseWidth){1'b0}}, trapCause};
        r_mtval  <= trapValue;
      end else begin
        if (w_wr_mepc)   r_mepc   <= csrWriteValue & AlignMask;
        if (w_wr_mcause) r_mcause <= csrWriteValue;
        if (w_wr_mtval)  r_mtval  <= csrWriteValue;
      end
    end
  end

  always_comb begin
    csrReadValue = 32'h0;
    case (csrReadAddr)
      AddrMtvec:  csrReadValue = r_mtvec;
      AddrMepc:   csrReadValue = r_mepc;
      AddrMcause: csrReadValue = r_mcause;
      AddrMtval:  csrReadValue = r_mtval;
      default:    csrReadValue = 32'h0;
    endcase
  end

  assign flush         = r_flush;
  assign redirectValid = r_redirect_valid;
  assign redirectPc    = r_redirect_pc;
  assign busy          = r_flush | r_redirect_valid;

endmodule
